// File: rtl/touch_scan_ctrl_if.sv
// Bus bundle between the touch scan sequencer and its pad / user-side environment.
interface touch_scan_ctrl_if #(
   parameter int NUM_PADS = 4,
   parameter int COUNT_W  = 8
);
   logic                en;
   logic                cal_req;
   logic [COUNT_W-1:0]  threshold;
   logic [NUM_PADS-1:0] pad_in;
   logic [NUM_PADS-1:0] pad_oe;
   logic [NUM_PADS-1:0] touched;
   logic                sample_valid;
   logic [2:0]          sample_ch;
   logic [COUNT_W-1:0]  sample_count;
   logic                timeout;
   logic                calibrated;
   logic                busy;

   modport master (
      output en, cal_req, threshold, pad_in,
      input  pad_oe, touched, sample_valid, sample_ch, sample_count,
             timeout, calibrated, busy
   );

   modport slave (
      input  en, cal_req, threshold, pad_in,
      output pad_oe, touched, sample_valid, sample_ch, sample_count,
             timeout, calibrated, busy
   );
endinterface

// File: rtl/touch_scan_ctrl.sv
// Round-robin capacitive touch scanner: discharge a pad, time its RC charge
// with one shared counter, and compare against a per-pad calibrated baseline.
module touch_scan_ctrl #(
   parameter int NUM_PADS     = 4,
   parameter int COUNT_W      = 8,
   parameter int DISCH_CYCLES = 16
) (
   input logic               clk,
   input logic               rst,
   touch_scan_ctrl_if.slave  bus
);
   localparam int unsigned CH_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
   localparam int unsigned DW   = $clog2(DISCH_CYCLES + 1);
   localparam logic [COUNT_W-1:0] MAX = '1;

   typedef enum logic [1:0] {IDLE, DISCH, MEAS, EVAL} state_t;

   state_t              state;
   logic [NUM_PADS-1:0] sync1;
   logic [NUM_PADS-1:0] pad_sync;
   logic [CH_W-1:0]     ch;
   logic [CH_W-1:0]     ch_next;
   logic [DW-1:0]       dcnt;
   logic [COUNT_W-1:0]  cnt;
   logic [COUNT_W-1:0]  baseline [NUM_PADS];
   logic                cal_pending;
   logic                cal_pending_nxt;
   logic                cal_mode;
   logic                last_ch;
   logic                pad_hit;
   logic [COUNT_W:0]    touch_level;

   logic [NUM_PADS-1:0] pad_oe;
   logic [NUM_PADS-1:0] touched;
   logic                sample_valid;
   logic [2:0]          sample_ch;
   logic [COUNT_W-1:0]  sample_count;
   logic                timeout;
   logic                calibrated;
   logic                busy;

   assign bus.pad_oe       = pad_oe;
   assign bus.touched      = touched;
   assign bus.sample_valid = sample_valid;
   assign bus.sample_ch    = sample_ch;
   assign bus.sample_count = sample_count;
   assign bus.timeout      = timeout;
   assign bus.calibrated   = calibrated;
   assign bus.busy         = busy;

   // Channel stepping, pad selection, touch level and pending-calibration update.
   always_comb begin
      last_ch     = (ch == CH_W'(NUM_PADS - 1));
      ch_next     = last_ch ? '0 : ch + CH_W'(1);
      pad_hit     = pad_sync[ch];
      touch_level = {1'b0, baseline[ch]} + {1'b0, bus.threshold};
      // A request arriving in the wrapping EVAL of a calibration pass survives the clear.
      cal_pending_nxt = cal_pending | bus.cal_req;
      if (state == EVAL && cal_mode && last_ch && !bus.cal_req)
         cal_pending_nxt = 1'b0;
   end

   // Two-flop synchroniser for the asynchronous pad levels.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1    <= '0;
         pad_sync <= '0;
      end else begin
         sync1    <= bus.pad_in;
         pad_sync <= sync1;
      end
   end

   // Scan sequencer with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         ch           <= '0;
         dcnt         <= '0;
         cnt          <= '0;
         for (int unsigned i = 0; i < NUM_PADS; i++)
            baseline[i] <= '0;
         cal_pending  <= 1'b1;
         cal_mode     <= 1'b0;
         pad_oe       <= '0;
         touched      <= '0;
         sample_valid <= 1'b0;
         sample_ch    <= '0;
         sample_count <= '0;
         timeout      <= 1'b0;
         calibrated   <= 1'b0;
         busy         <= 1'b0;
      end else begin
         cal_pending  <= cal_pending_nxt;
         sample_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.en) begin
                  state  <= DISCH;
                  busy   <= 1'b1;
                  dcnt   <= '0;
                  pad_oe <= NUM_PADS'(1) << ch;
                  if (ch == '0)
                     cal_mode <= cal_pending_nxt;
               end
            end
            DISCH: begin
               if (dcnt == DW'(DISCH_CYCLES - 1)) begin
                  state  <= MEAS;
                  pad_oe <= '0;
                  cnt    <= '0;
               end else begin
                  dcnt <= dcnt + DW'(1);
               end
            end
            MEAS: begin
               if (pad_hit) begin
                  state        <= EVAL;
                  sample_valid <= 1'b1;
                  sample_ch    <= 3'(ch);
                  sample_count <= cnt;
                  timeout      <= 1'b0;
               end else if (cnt == MAX) begin
                  state        <= EVAL;
                  sample_valid <= 1'b1;
                  sample_ch    <= 3'(ch);
                  sample_count <= MAX;
                  timeout      <= 1'b1;
               end else begin
                  cnt <= cnt + COUNT_W'(1);
               end
            end
            EVAL: begin
               if (cal_mode) begin
                  baseline[ch] <= sample_count;
                  touched[ch]  <= 1'b0;
               end else begin
                  touched[ch] <= ({1'b0, sample_count} >= touch_level);
               end
               if (last_ch && cal_mode)
                  calibrated <= 1'b1;
               ch <= ch_next;
               if (bus.en) begin
                  state  <= DISCH;
                  dcnt   <= '0;
                  pad_oe <= NUM_PADS'(1) << ch_next;
                  if (last_ch)
                     cal_mode <= cal_pending_nxt;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               busy   <= 1'b0;
               pad_oe <= '0;
            end
         endcase
      end
   end
endmodule
